ranging_ctrl: RTL and testbench
===============================

Name: ranging_ctrl

Overview:
Measurement sequencer for the ultrasonic ranging path. It issues periodic trigger pulses and synchronises the echo input. It counts the echo high time in clk_34 ticks as a three-digit BCD value. It delivers each valid sample to the averaging filter as a packed {ones,tens,hundreds} word with a one-cycle strobe, and reports missing or stuck echoes as timeouts.

Parameters:
TRIG_CYCLES, 1, trigger pulse width in clk_34 cycles (1..255)
TIMEOUT, 1200, max cycles allowed in WAIT_RISE, and separately in MEASURE (2..65535)
PERIOD, 2048, cycles from one trigger start to the next (must exceed TRIG_CYCLES+2*TIMEOUT+4; max 65535)

Ports:
clk_34  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  level; 1 = run periodic measurements
echo  in  1  asynchronous sensor echo
trig  out  1  registered sensor trigger pulse
raw  out  12  last valid sample, {ones[11:8],tens[7:4],hundreds[3:0]}, BCD digits
raw_valid  out  1  one-cycle strobe; raw updated in the same cycle
sat  out  1  1 if the sample in raw saturated at 999
timeout_err  out  1  one-cycle strobe on timeout
busy  out  1  1 whenever FSM is not IDLE

Behaviour:
- Echo synchroniser: two flops, echo_m then echo_s, plus echo_d = echo_s delayed one cycle. Echo rise is echo_s & ~echo_d. Pin-to-echo_s latency is 2 cycles. All three flops clear on reset.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE: trig=0.
  - enable=1: go to TRIG next edge, clear period_cnt to 0, clear bcd_cnt to 000.
- TRIG: trig=1 for exactly TRIG_CYCLES cycles (registered; high in the first TRIG cycle), then go to WAIT_RISE with the timer cleared.
- WAIT_RISE:
  - Echo rise: go to MEASURE, load bcd_cnt=001.
  - Echo already high on entry without a 0->1 edge is ignored.
  - Timer reaches TIMEOUT-1 with no rise: timeout_err=1 for one cycle, raw/sat unchanged, go to HOLDOFF.
- MEASURE: timer cleared on entry.
  - Each cycle with echo_s=1: bcd_cnt increments in BCD. Ones 9->0 carries to tens; tens 9->0 carries to hundreds.
  - bcd_cnt saturates at 999 and sets internal sat flag.
  - echo_s=0: at that edge raw<=bcd_cnt, sat<=flag, raw_valid=1 for one cycle, go to HOLDOFF.
  - Result: echo high N cycles at the pin gives raw=min(N,999).
  - Timer reaches TIMEOUT-1 with echo still high: timeout_err pulse, raw unchanged, go to HOLDOFF.
- HOLDOFF: wait for period_cnt == PERIOD-1.
  - enable=1: go to TRIG, period_cnt cleared to 0.
  - enable=0: go to IDLE.
- period_cnt: increments every non-IDLE cycle, saturating at PERIOD-1. Consecutive trig rising edges are exactly PERIOD cycles apart while enable stays 1.
- enable deasserted mid-measurement: the current measurement completes normally (sample or timeout), then the FSM returns to IDLE. enable is not sampled outside IDLE and HOLDOFF.
- raw_valid and timeout_err are never both 1. Each fires at most once per trigger.
- busy = (state != IDLE), registered with the state.
- Reset, including mid-operation, forces at the next edge: state=IDLE, trig=0, raw=12'h000, sat=0, raw_valid=0, timeout_err=0, busy=0, all counters and timers 0.
- Widths: timer and period_cnt 16 bits; bcd_cnt 12 bits; no binary intermediate.

Test Plan:
1. TRIG_CYCLES=2, TIMEOUT=64, PERIOD=200. enable=1, echo pulse 37 cycles wide starting 5 cycles after trig falls -> trig high 2 cycles; raw=12'h730 (ones 7, tens 3, hundreds 0), sat=0, raw_valid single pulse; next trig rises 200 cycles after the first.
2. TIMEOUT=2048, PERIOD=5000. Echo pulses of 9, 10, 99, 100 and 1005 cycles -> raw 12'h900, 12'h010, 12'h990, 12'h001, 12'h999; sat=1 only for the 1005-cycle pulse.
3. TIMEOUT=64. Echo held low after trigger -> timeout_err pulse 64 cycles after WAIT_RISE entry; raw keeps its previous value; no raw_valid. Then echo held high through the whole cycle -> timeout in WAIT_RISE (no edge); no raw_valid.
4. TIMEOUT=64. Echo rises and stays high 100 cycles -> timeout_err during MEASURE; raw unchanged; next trig still lands on the PERIOD boundary.
5. Drop enable during MEASURE (echo 20 cycles) -> raw=12'h020 delivered, FSM reaches IDLE at the period boundary, no further trig, busy=0.
6. Assert reset for 1 cycle mid-MEASURE -> next cycle all outputs at reset values; with enable still 1, re-trigger one cycle after reset release.

Source files
------------

// File: rtl/ranging_ctrl.sv
// Ultrasonic ranging sequencer: periodic trigger, synchronised echo capture,
// echo width counted directly in BCD, with sample strobe and timeout reporting.
module ranging_ctrl #(
    parameter int TRIG_CYCLES = 1,
    parameter int TIMEOUT     = 1200,
    parameter int PERIOD      = 2048
) (
    input  logic        clk_34,
    input  logic        reset,
    input  logic        enable,
    input  logic        echo,
    output logic        trig,
    output logic [11:0] raw,
    output logic        raw_valid,
    output logic        sat,
    output logic        timeout_err,
    output logic        busy
);

    localparam logic [15:0] TRIG_LAST = 16'(TRIG_CYCLES - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [15:0] PER_LAST  = 16'(PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } state_t;

    state_t      state, state_next;
    logic [15:0] timer, timer_next;
    logic [15:0] period_cnt, period_next;
    logic [11:0] bcd_cnt, bcd_next;
    logic        sat_flag, sat_flag_next;
    logic        sample, tmo;

    logic echo_m, echo_s, echo_d;
    logic echo_rise;

    // bcd_cnt is held as {hundreds,tens,ones}; it is reordered only when loaded into raw
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] h, t, o;
        {h, t, o} = v;
        if (o == 4'd9) begin
            o = 4'd0;
            if (t == 4'd9) begin
                t = 4'd0;
                h = h + 4'd1;
            end else begin
                t = t + 4'd1;
            end
        end else begin
            o = o + 4'd1;
        end
        return {h, t, o};
    endfunction

    always_ff @(posedge clk_34) begin
        if (reset) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
            echo_d <= echo_s;
        end
    end

    assign echo_rise = echo_s & ~echo_d;

    always_comb begin
        state_next    = state;
        timer_next    = timer;
        period_next   = period_cnt;
        bcd_next      = bcd_cnt;
        sat_flag_next = sat_flag;
        sample        = 1'b0;
        tmo           = 1'b0;

        if (state != IDLE && period_cnt != PER_LAST) begin
            period_next = period_cnt + 16'd1;
        end

        case (state)
            IDLE: begin
                if (enable) begin
                    state_next    = TRIG;
                    period_next   = 16'd0;
                    timer_next    = 16'd0;
                    bcd_next      = 12'h000;
                    sat_flag_next = 1'b0;
                end
            end
            TRIG: begin
                if (timer == TRIG_LAST) begin
                    state_next = WAIT_RISE;
                    timer_next = 16'd0;
                end else begin
                    timer_next = timer + 16'd1;
                end
            end
            WAIT_RISE: begin
                // Only a genuine 0->1 edge starts a measurement, never a level held from before
                if (echo_rise) begin
                    state_next    = MEASURE;
                    timer_next    = 16'd0;
                    bcd_next      = 12'h001;
                    sat_flag_next = 1'b0;
                end else if (timer == TMO_LAST) begin
                    state_next = HOLDOFF;
                    timer_next = 16'd0;
                    tmo        = 1'b1;
                end else begin
                    timer_next = timer + 16'd1;
                end
            end
            MEASURE: begin
                if (!echo_s) begin
                    state_next = HOLDOFF;
                    timer_next = 16'd0;
                    sample     = 1'b1;
                end else begin
                    // sat marks a true width beyond 999, not a width of exactly 999
                    if (bcd_cnt == 12'h999) begin
                        sat_flag_next = 1'b1;
                    end else begin
                        bcd_next = bcd_inc(bcd_cnt);
                    end
                    if (timer == TMO_LAST) begin
                        state_next = HOLDOFF;
                        timer_next = 16'd0;
                        tmo        = 1'b1;
                    end else begin
                        timer_next = timer + 16'd1;
                    end
                end
            end
            HOLDOFF: begin
                if (period_cnt == PER_LAST) begin
                    if (enable) begin
                        state_next    = TRIG;
                        period_next   = 16'd0;
                        timer_next    = 16'd0;
                        bcd_next      = 12'h000;
                        sat_flag_next = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_34) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= 16'd0;
            period_cnt  <= 16'd0;
            bcd_cnt     <= 12'h000;
            sat_flag    <= 1'b0;
            trig        <= 1'b0;
            raw         <= 12'h000;
            raw_valid   <= 1'b0;
            sat         <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            period_cnt  <= period_next;
            bcd_cnt     <= bcd_next;
            sat_flag    <= sat_flag_next;
            trig        <= (state_next == TRIG);
            busy        <= (state_next != IDLE);
            raw_valid   <= sample;
            timeout_err <= tmo;
            if (sample) begin
                raw <= {bcd_cnt[3:0], bcd_cnt[7:4], bcd_cnt[11:8]};
                sat <= sat_flag;
            end
        end
    end

endmodule

// File: tb/tb_ranging_ctrl.sv
// Self-checking bench for ranging_ctrl: scoreboard of expected samples/timeouts
// checked by a monitor, plus per-scenario timing checks on trig and busy.
module tb_ranging_ctrl;

    localparam int TRIG_CYCLES = 2;
    localparam int TIMEOUT     = 1100;
    localparam int PERIOD      = 2400;

    logic        clk_34;
    logic        reset;
    logic        enable;
    logic        echo;
    logic        trig;
    logic [11:0] raw;
    logic        raw_valid;
    logic        sat;
    logic        timeout_err;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle        = 0;

    typedef struct {
        logic        is_timeout;
        logic [11:0] raw;
        logic        sat;
    } exp_t;

    exp_t        sb[$];
    logic [11:0] model_raw = 12'h000;
    logic        model_sat = 1'b0;

    ranging_ctrl #(
        .TRIG_CYCLES(TRIG_CYCLES),
        .TIMEOUT    (TIMEOUT),
        .PERIOD     (PERIOD)
    ) dut (
        .clk_34     (clk_34),
        .reset      (reset),
        .enable     (enable),
        .echo       (echo),
        .trig       (trig),
        .raw        (raw),
        .raw_valid  (raw_valid),
        .sat        (sat),
        .timeout_err(timeout_err),
        .busy       (busy)
    );

    initial begin
        clk_34 = 1'b0;
        forever #5 clk_34 = ~clk_34;
    end

    always @(posedge clk_34) cycle <= cycle + 1;

    initial begin
        #(900_000);
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [11:0] exp_raw(input int n);
        int m;
        m = (n > 999) ? 999 : n;
        return {4'(m % 10), 4'((m / 10) % 10), 4'(m / 100)};
    endfunction

    function automatic void push_sample(input int n);
        exp_t e;
        model_raw    = exp_raw(n);
        model_sat    = (n > 999);
        e.is_timeout = 1'b0;
        e.raw        = model_raw;
        e.sat        = model_sat;
        sb.push_back(e);
    endfunction

    function automatic void push_timeout();
        exp_t e;
        e.is_timeout = 1'b1;
        e.raw        = model_raw;
        e.sat        = model_sat;
        sb.push_back(e);
    endfunction

    // Every strobe from the DUT must match the oldest outstanding expectation
    always @(negedge clk_34) begin
        exp_t e;
        if (raw_valid === 1'b1 && timeout_err === 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL strobe_exclusive: raw_valid=1 timeout_err=1 required not both");
        end else if (raw_valid === 1'b1 || timeout_err === 1'b1) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_event: raw_valid=%0b timeout_err=%0b with nothing expected",
                         raw_valid, timeout_err);
            end else begin
                e = sb.pop_front();
                if (timeout_err !== e.is_timeout || raw !== e.raw || sat !== e.sat) begin
                    tests_failed++;
                    $display("[TB] FAIL event: got timeout=%0b raw=%h sat=%0b expected timeout=%0b raw=%h sat=%0b",
                             timeout_err, raw, sat, e.is_timeout, e.raw, e.sat);
                end
            end
        end
    end

    task automatic wait_sb_empty(input int budget, input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk_34);
            k++;
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL %s: %0d events outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_trig_rise(output int at);
        logic was;
        int   k;
        bit   seen;
        was  = trig;
        k    = 0;
        seen = 0;
        at   = -1;
        while (!seen && k < 2 * PERIOD + 100) begin
            @(negedge clk_34);
            k++;
            if (trig === 1'b1 && was !== 1'b1) begin
                seen = 1;
                at   = cycle;
            end
            was = trig;
        end
        if (!seen) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL trig_rise_wait: no trig rising edge within %0d cycles", k);
        end
    endtask

    // Entered right after a trig rise; returns the trig width in cycles
    task automatic wait_trig_fall(output int width);
        int k;
        width = 1;
        k     = 0;
        @(negedge clk_34);
        while (trig === 1'b1 && k < 300) begin
            width++;
            k++;
            @(negedge clk_34);
        end
    endtask

    task automatic measure(input int n, input int delay, output int width);
        wait_trig_fall(width);
        repeat (delay) @(negedge clk_34);
        echo = 1'b1;
        repeat (n) @(negedge clk_34);
        push_sample(n);
        echo = 1'b0;
        wait_sb_empty(50, "sample_delivery");
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        echo   = 1'b0;
        repeat (3) @(negedge clk_34);
        tests_run += 6;
        if (trig !== 1'b0)        begin tests_failed++; $display("[TB] FAIL reset_trig: got %b required 0", trig); end
        if (raw !== 12'h000)      begin tests_failed++; $display("[TB] FAIL reset_raw: got %h required 000", raw); end
        if (raw_valid !== 1'b0)   begin tests_failed++; $display("[TB] FAIL reset_raw_valid: got %b required 0", raw_valid); end
        if (sat !== 1'b0)         begin tests_failed++; $display("[TB] FAIL reset_sat: got %b required 0", sat); end
        if (timeout_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_timeout: got %b required 0", timeout_err); end
        if (busy !== 1'b0)        begin tests_failed++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
        reset = 1'b0;
        repeat (5) @(negedge clk_34);
        tests_run++;
        if (busy !== 1'b0 || trig !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_disabled: busy=%b trig=%b required 0 0", busy, trig);
        end
    endtask

    task automatic test_basic(output int first_rise);
        int width;
        enable = 1'b1;
        wait_trig_rise(first_rise);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL busy_active: got %b required 1", busy);
        end
        measure(37, 5, width);
        tests_run++;
        if (width != TRIG_CYCLES) begin
            tests_failed++;
            $display("[TB] FAIL trig_width: got %0d required %0d", width, TRIG_CYCLES);
        end
    endtask

    task automatic test_period(input int first_rise);
        int r;
        int width;
        wait_trig_rise(r);
        tests_run++;
        if (r - first_rise != PERIOD) begin
            tests_failed++;
            $display("[TB] FAIL trig_period: got %0d required %0d", r - first_rise, PERIOD);
        end
        measure(9, 3, width);
    endtask

    task automatic test_bcd_digits();
        int widths[4] = '{10, 99, 100, 1005};
        int r;
        int width;
        foreach (widths[i]) begin
            wait_trig_rise(r);
            measure(widths[i], 4, width);
        end
    endtask

    task automatic test_timeout_low();
        int r;
        int width;
        int fall_cycle;
        int k;
        wait_trig_rise(r);
        wait_trig_fall(width);
        fall_cycle = cycle;
        push_timeout();
        k = 0;
        while (timeout_err !== 1'b1 && k < TIMEOUT + 200) begin
            @(negedge clk_34);
            k++;
        end
        tests_run++;
        if (cycle - fall_cycle != TIMEOUT) begin
            tests_failed++;
            $display("[TB] FAIL wait_rise_timeout_delay: got %0d required %0d", cycle - fall_cycle, TIMEOUT);
        end
        wait_sb_empty(10, "wait_rise_timeout");
    endtask

    task automatic test_timeout_high();
        int r;
        echo = 1'b1;
        wait_trig_rise(r);
        push_timeout();
        wait_sb_empty(TIMEOUT + 200, "stuck_high_timeout");
        echo = 1'b0;
    endtask

    task automatic test_measure_timeout(output int next_rise);
        int r;
        int width;
        wait_trig_rise(r);
        wait_trig_fall(width);
        repeat (5) @(negedge clk_34);
        echo = 1'b1;
        push_timeout();
        repeat (TIMEOUT + 100) @(negedge clk_34);
        echo = 1'b0;
        wait_sb_empty(10, "measure_timeout");
        wait_trig_rise(next_rise);
        tests_run++;
        if (next_rise - r != PERIOD) begin
            tests_failed++;
            $display("[TB] FAIL period_after_timeout: got %0d required %0d", next_rise - r, PERIOD);
        end
    endtask

    task automatic test_enable_drop(input int rise_cycle);
        int   width;
        int   k;
        int   rises;
        logic was;
        wait_trig_fall(width);
        repeat (5) @(negedge clk_34);
        echo = 1'b1;
        repeat (8) @(negedge clk_34);
        enable = 1'b0;
        repeat (12) @(negedge clk_34);
        push_sample(20);
        echo = 1'b0;
        wait_sb_empty(50, "enable_drop_sample");
        k = 0;
        while (busy !== 1'b0 && k < PERIOD + 100) begin
            @(negedge clk_34);
            k++;
        end
        tests_run++;
        if (cycle - rise_cycle != PERIOD) begin
            tests_failed++;
            $display("[TB] FAIL idle_at_boundary: got %0d required %0d", cycle - rise_cycle, PERIOD);
        end
        rises = 0;
        was   = trig;
        repeat (PERIOD + 200) begin
            @(negedge clk_34);
            if (trig === 1'b1 && was !== 1'b1) rises++;
            was = trig;
        end
        tests_run++;
        if (rises != 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stays_idle: got rises=%0d busy=%b required 0 0", rises, busy);
        end
    endtask

    task automatic test_reset_mid();
        int r;
        int width;
        enable = 1'b1;
        wait_trig_rise(r);
        wait_trig_fall(width);
        repeat (5) @(negedge clk_34);
        echo = 1'b1;
        repeat (10) @(negedge clk_34);
        reset = 1'b1;
        echo  = 1'b0;
        @(negedge clk_34);
        model_raw = 12'h000;
        model_sat = 1'b0;
        tests_run++;
        if (trig !== 1'b0 || raw !== 12'h000 || raw_valid !== 1'b0 ||
            sat !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset: got trig=%b raw=%h rv=%b sat=%b tmo=%b busy=%b required all 0",
                     trig, raw, raw_valid, sat, timeout_err, busy);
        end
        reset = 1'b0;
        @(negedge clk_34);
        tests_run++;
        if (trig !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL retrigger_after_reset: got trig=%b required 1", trig);
        end
        measure(15, 5, width);
        enable = 1'b0;
    endtask

    initial begin
        int first_rise;
        int next_rise;
        test_reset();
        test_basic(first_rise);
        test_period(first_rise);
        test_bcd_digits();
        test_timeout_low();
        test_timeout_high();
        test_measure_timeout(next_rise);
        test_enable_drop(next_rise);
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
